// File: rtl/program_mem_arbiter.sv
// Round-robin arbiter sharing one program-memory read channel among the per-core icache miss ports.
// Optional PMEM_ARB_COALESCE_EN: serve every requester of the granted address from a single memory read.
module program_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic [1:0]                         o_dbg_state
);

  // Handshake: a consumer holds valid until its one-cycle ready pulse; the memory side holds
  // valid/address stable until mem_read_ready, which marks the cycle mem_read_data is sampled.

  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_READ    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]                         r_state;
  logic [IDX_W-1:0]                   r_last_grant;
  logic [IDX_W-1:0]                   r_grant;
  logic [ADDR_BITS-1:0]               r_addr;
  logic                               r_mem_valid;
  logic [NUM_CONSUMERS-1:0]           r_ready;
  logic [NUM_CONSUMERS-1:0]           r_mask;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] r_data;

  logic                               w_found;
  logic [IDX_W-1:0]                   w_winner;
  logic [IDX_W-1:0]                   w_idx;
  logic [ADDR_BITS-1:0]               w_win_addr;
  logic [NUM_CONSUMERS-1:0]           w_mask;
  logic                               w_release_done;

  // Search starts just past the previous grant so a busy requester cannot win twice in a row.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int off = 1; off <= NUM_CONSUMERS; off++) begin
      w_idx = IDX_W'((int'(r_last_grant) + off) % NUM_CONSUMERS);
      if (!w_found && consumer_read_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_win_addr = consumer_read_address[w_winner*ADDR_BITS +: ADDR_BITS];

  // The winner is always served, even if it dropped valid while the read was in flight.
  always_comb begin
    w_mask          = '0;
    w_mask[r_grant] = 1'b1;
`ifdef PMEM_ARB_COALESCE_EN
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      if (consumer_read_valid[i] &&
          consumer_read_address[i*ADDR_BITS +: ADDR_BITS] == r_addr) begin
        w_mask[i] = 1'b1;
      end
    end
`endif
  end

  assign w_release_done = ~|(consumer_read_valid & r_mask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= IDX_W'(NUM_CONSUMERS - 1);
      r_grant      <= '0;
      r_addr       <= '0;
      r_mem_valid  <= 1'b0;
      r_ready      <= '0;
      r_mask       <= '0;
      r_data       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= '0;
          if (w_found) begin
            r_grant     <= w_winner;
            r_addr      <= w_win_addr;
            r_mem_valid <= 1'b1;
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          if (mem_read_ready) begin
            r_mem_valid  <= 1'b0;
            r_ready      <= w_mask;
            r_mask       <= w_mask;
            r_last_grant <= r_grant;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
              if (w_mask[i]) r_data[i*DATA_BITS +: DATA_BITS] <= mem_read_data;
            end
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          r_ready <= '0;
          if (w_release_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign consumer_read_ready = r_ready;
  assign consumer_read_data  = r_data;
  assign mem_read_valid      = r_mem_valid;
  assign mem_read_address    = r_addr;
  assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_program_mem_arbiter.sv
// Directed bench for program_mem_arbiter: single read, round robin, stalled memory,
// asynchronous reset mid-read, identical-address requesters and a winner dropping valid.
module tb_program_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  valid;
  logic [31:0] addrs;
  logic [3:0]  c_ready;
  logic [63:0] c_data;
  logic        m_valid;
  logic [7:0]  m_addr;
  logic        m_ready;
  logic [15:0] m_data;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_READ    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  program_mem_arbiter #(.NUM_CONSUMERS(4), .ADDR_BITS(8), .DATA_BITS(16)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (valid),
    .consumer_read_address (addrs),
    .consumer_read_ready   (c_ready),
    .consumer_read_data    (c_data),
    .mem_read_valid        (m_valid),
    .mem_read_address      (m_addr),
    .mem_read_ready        (m_ready),
    .mem_read_data         (m_data),
    .o_dbg_state           (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a);
    valid[i]         = 1'b1;
    addrs[i*8 +: 8]  = a;
  endtask

  task automatic clr_req(input int i);
    valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    valid   = '0;
    addrs   = '0;
    m_ready = 1'b0;
    m_data  = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [15:0] dslice(input int i);
    return c_data[i*16 +: 16];
  endfunction

  // scoreboard check
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset   = 1'b1;
    valid   = '0;
    addrs   = '0;
    m_ready = 1'b0;
    m_data  = '0;
    #1;
    chk("rst_mem_valid", 64'(m_valid), 64'd0);
    chk("rst_mem_addr",  64'(m_addr),  64'd0);
    chk("rst_ready",     64'(c_ready), 64'd0);
    chk("rst_data",      c_data,       64'd0);
    chk("rst_state",     64'(dbg_state), 64'(ST_IDLE));

    // single request from consumer 2
    do_reset();
    set_req(2, 8'h15);
    tick();
    chk("s1_mem_valid", 64'(m_valid), 64'd1);
    chk("s1_mem_addr",  64'(m_addr),  64'h15);
    chk("s1_no_ready",  64'(c_ready), 64'd0);
    m_ready = 1'b1;
    m_data  = 16'hBEEF;
    tick();
    m_ready = 1'b0;
    chk("s1_ready",     64'(c_ready),   64'b0100);
    chk("s1_data",      64'(dslice(2)), 64'hBEEF);
    chk("s1_mem_drop",  64'(m_valid),   64'd0);
    tick();
    chk("s1_pulse_end", 64'(c_ready),   64'd0);
    chk("s1_release",   64'(dbg_state), 64'(ST_RELEASE));
    tick();
    chk("s1_no_second", 64'(c_ready),   64'd0);
    chk("s1_data_hold", 64'(dslice(2)), 64'hBEEF);
    clr_req(2);
    tick();
    chk("s1_idle",      64'(dbg_state), 64'(ST_IDLE));

    // round robin with all four consumers requesting
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 8'(i * 16));
    tick();
    for (int n = 0; n < 5; n++) begin
      chk("rr_mem_valid", 64'(m_valid), 64'd1);
      chk("rr_mem_addr",  64'(m_addr),  64'(exp_order[n] * 16));
      m_ready = 1'b1;
      m_data  = 16'hA000 + 16'(n);
      tick();
      m_ready = 1'b0;
      chk("rr_ready", 64'(c_ready), 64'(4'b0001 << exp_order[n]));
      chk("rr_data",  64'(dslice(exp_order[n])), 64'(16'hA000 + 16'(n)));
      clr_req(exp_order[n]);
      tick();
      chk("rr_idle", 64'(dbg_state), 64'(ST_IDLE));
      set_req(exp_order[n], 8'(exp_order[n] * 16));
      tick();
    end
    chk("rr_slice1_hold", 64'(dslice(1)), 64'hA001);

    // stalled memory: ten cycles without mem_read_ready
    do_reset();
    set_req(0, 8'h05);
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("stall_valid", 64'(m_valid), 64'd1);
      chk("stall_addr",  64'(m_addr),  64'h05);
      if (c == 2) set_req(1, 8'h06);
      tick();
    end
    m_ready = 1'b1;
    m_data  = 16'h1111;
    tick();
    m_ready = 1'b0;
    chk("stall_ready", 64'(c_ready), 64'b0001);
    tick();
    chk("stall_hold0", 64'(m_valid), 64'd0);
    tick();
    chk("stall_hold1", 64'(m_valid), 64'd0);
    clr_req(0);
    tick();
    chk("stall_gap", 64'(m_valid), 64'd0);
    tick();
    chk("stall_next_valid", 64'(m_valid), 64'd1);
    chk("stall_next_addr",  64'(m_addr),  64'h06);
    m_ready = 1'b1;
    m_data  = 16'h2222;
    tick();
    m_ready = 1'b0;
    chk("stall_next_ready", 64'(c_ready), 64'b0010);
    clr_req(1);
    tick();

    // asynchronous reset in the middle of a read
    do_reset();
    set_req(0, 8'h01);
    tick();
    m_ready = 1'b1;
    m_data  = 16'h0101;
    tick();
    m_ready = 1'b0;
    clr_req(0);
    tick();
    set_req(1, 8'h02);
    tick();
    chk("ar_read_addr", 64'(m_addr), 64'h02);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_valid_drop", 64'(m_valid),   64'd0);
    chk("ar_state",      64'(dbg_state), 64'(ST_IDLE));
    m_ready = 1'b1;
    m_data  = 16'hDEAD;
    clr_req(1);
    tick();
    reset   = 1'b0;
    m_ready = 1'b0;
    tick();
    chk("ar_no_pulse", 64'(c_ready),   64'd0);
    chk("ar_no_data",  64'(dslice(1)), 64'd0);
    set_req(0, 8'h01);
    set_req(1, 8'h02);
    tick();
    chk("ar_next_grant0", 64'(m_addr), 64'h01);
    m_ready = 1'b1;
    m_data  = 16'h0303;
    tick();
    m_ready = 1'b0;
    chk("ar_ready0", 64'(c_ready), 64'b0001);
    valid = '0;
    tick();
    tick();

    // identical address from consumers 0 and 3
    do_reset();
    set_req(0, 8'h42);
    set_req(3, 8'h42);
    tick();
    chk("co_addr", 64'(m_addr), 64'h42);
    m_ready = 1'b1;
    m_data  = 16'h1234;
    tick();
    m_ready = 1'b0;
`ifdef PMEM_ARB_COALESCE_EN
    chk("co_ready",  64'(c_ready),   64'b1001);
    chk("co_data0",  64'(dslice(0)), 64'h1234);
    chk("co_data3",  64'(dslice(3)), 64'h1234);
    valid = '0;
    tick();
    tick();
    chk("co_one_read", 64'(m_valid), 64'd0);
`else
    chk("co_ready0", 64'(c_ready),   64'b0001);
    chk("co_data0",  64'(dslice(0)), 64'h1234);
    chk("co_data3u", 64'(dslice(3)), 64'd0);
    clr_req(0);
    tick();
    tick();
    chk("co_second_valid", 64'(m_valid), 64'd1);
    chk("co_second_addr",  64'(m_addr),  64'h42);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("co_ready3", 64'(c_ready),   64'b1000);
    chk("co_data3",  64'(dslice(3)), 64'h1234);
    valid = '0;
    tick();
`endif

    // winner drops valid while its read is in flight
    do_reset();
    set_req(2, 8'h33);
    tick();
    clr_req(2);
    tick();
    chk("wd_held", 64'(m_valid), 64'd1);
    m_ready = 1'b1;
    m_data  = 16'h5A5A;
    tick();
    m_ready = 1'b0;
    chk("wd_ready", 64'(c_ready),   64'b0100);
    chk("wd_data",  64'(dslice(2)), 64'h5A5A);
    tick();
    chk("wd_idle",     64'(dbg_state), 64'(ST_IDLE));
    chk("wd_pulse_end", 64'(c_ready),  64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
